// File: rtl/axi4_mem_periph_multi.sv
// rtl/axi4_mem_periph_multi.sv - AXI4-lite RAM model with console, pass flag and per-channel accelerator registers
module axi4_mem_periph_multi #(
  parameter int          MEM_WORDS    = 32768,
  parameter int          READ_LATENCY = 1,
  parameter int          NUM_CH       = 2,
  parameter logic [31:0] PERIPH_BASE  = 32'h3000_0000,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] PASS_ADDR    = 32'h2100_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_axi_awvalid,
  output logic                  mem_axi_awready,
  input  logic [31:0]           mem_axi_awaddr,
  input  logic                  mem_axi_wvalid,
  output logic                  mem_axi_wready,
  input  logic [31:0]           mem_axi_wdata,
  input  logic [3:0]            mem_axi_wstrb,
  output logic                  mem_axi_bvalid,
  input  logic                  mem_axi_bready,
  output logic [1:0]            mem_axi_bresp,
  input  logic                  mem_axi_arvalid,
  output logic                  mem_axi_arready,
  input  logic [31:0]           mem_axi_araddr,
  output logic                  mem_axi_rvalid,
  input  logic                  mem_axi_rready,
  output logic [31:0]           mem_axi_rdata,
  output logic [1:0]            mem_axi_rresp,
  output logic [NUM_CH*32-1:0]  ch_a,
  output logic [NUM_CH*32-1:0]  ch_b,
  output logic [NUM_CH-1:0]     ch_start,
  input  logic [NUM_CH-1:0]     ch_rdy,
  input  logic [NUM_CH*64-1:0]  ch_p,
  output logic                  console_valid,
  output logic [7:0]            console_data,
  output logic                  tests_passed
);

  localparam int          IW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
  localparam logic [31:0] WIN_BYTES = 32'(NUM_CH) << 5;
  localparam logic [2:0]  WAIT_INIT = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [31:0] mem [0:MEM_WORDS-1];

  // ---------------- write channel ----------------
  w_state_t    w_state, w_next;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_fire, w_fire, commit;
  logic [31:0] wa, wd;
  logic [3:0]  ws;
  logic [31:0] wr_rel;
  logic        wr_ram, wr_con, wr_pass, wr_win, wr_ok;
  logic [2:0]  wr_ch, wr_off;

  assign mem_axi_awready = (w_state == W_IDLE) && !aw_got && !reset;
  assign mem_axi_wready  = (w_state == W_IDLE) && !w_got && !reset;
  assign mem_axi_bvalid  = (w_state == W_RESP);
  assign aw_fire = mem_axi_awvalid && mem_axi_awready;
  assign w_fire  = mem_axi_wvalid && mem_axi_wready;

  // Either half may already be latched from an earlier cycle; commit once both are present.
  assign wa = aw_got ? aw_addr_q : mem_axi_awaddr;
  assign wd = w_got ? w_data_q : mem_axi_wdata;
  assign ws = w_got ? w_strb_q : mem_axi_wstrb;
  assign commit = (w_state == W_IDLE) && (aw_got || aw_fire) && (w_got || w_fire) && !reset;

  always_comb begin
    wr_rel  = wa - PERIPH_BASE;
    wr_ram  = ({1'b0, wa} < MEM_BYTES);
    wr_con  = !wr_ram && (wa == CONSOLE_ADDR);
    wr_pass = !wr_ram && (wa == PASS_ADDR);
    wr_win  = !wr_ram && (wa >= PERIPH_BASE) && (wr_rel < WIN_BYTES);
    wr_ch   = wr_rel[7:5];
    wr_off  = wr_rel[4:2];
    wr_ok   = wr_ram || wr_con || wr_pass || (wr_win && (wr_off <= 3'd2));
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_next = W_RESP;
      W_RESP:  if (mem_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state       <= W_IDLE;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      mem_axi_bresp <= 2'b00;
    end else begin
      w_state <= w_next;
      if (commit) begin
        aw_got        <= 1'b0;
        w_got         <= 1'b0;
        mem_axi_bresp <= wr_ok ? 2'b00 : 2'b10;
      end else begin
        if (aw_fire) begin
          aw_got    <= 1'b1;
          aw_addr_q <= mem_axi_awaddr;
        end
        if (w_fire) begin
          w_got    <= 1'b1;
          w_data_q <= mem_axi_wdata;
          w_strb_q <= mem_axi_wstrb;
        end
      end
    end
  end

  // RAM is deliberately left out of reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (commit && wr_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) mem[wa[IW+1:2]][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_a          <= '0;
      ch_b          <= '0;
      ch_start      <= '0;
      console_valid <= 1'b0;
      console_data  <= 8'h00;
      tests_passed  <= 1'b0;
    end else begin
      ch_start      <= '0;
      console_valid <= 1'b0;
      if (commit) begin
        if (wr_con) begin
          console_valid <= 1'b1;
          console_data  <= wd[7:0];
        end
        if (wr_pass && (wd == 32'h1)) tests_passed <= 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_win && (wr_ch == 3'(i))) begin
            if (wr_off == 3'd0) ch_start[i] <= wd[0];
            for (int b = 0; b < 4; b++) begin
              if (ws[b] && (wr_off == 3'd1)) ch_a[32*i + 8*b +: 8] <= wd[8*b +: 8];
              if (ws[b] && (wr_off == 3'd2)) ch_b[32*i + 8*b +: 8] <= wd[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t    r_state, r_next;
  logic [31:0] ar_addr_q, ra, rd_rel, rd_val;
  logic [2:0]  wait_cnt, rd_ch, rd_off;
  logic        ar_fire, rd_ok, enter_data;

  assign mem_axi_arready = (r_state == R_IDLE) && !reset;
  assign mem_axi_rvalid  = (r_state == R_DATA);
  assign ar_fire = mem_axi_arvalid && mem_axi_arready;
  // With one-cycle latency the address is decoded straight off the bus in the accept cycle.
  assign ra = (r_state == R_IDLE) ? mem_axi_araddr : ar_addr_q;

  always_comb begin
    rd_ok  = 1'b0;
    rd_val = 32'h0;
    rd_rel = ra - PERIPH_BASE;
    rd_ch  = rd_rel[7:5];
    rd_off = rd_rel[4:2];
    if ({1'b0, ra} < MEM_BYTES) begin
      rd_ok  = 1'b1;
      rd_val = mem[ra[IW+1:2]];
    end else if (ra == PASS_ADDR) begin
      rd_ok  = 1'b1;
      rd_val = {31'b0, tests_passed};
    end else if ((ra >= PERIPH_BASE) && (rd_rel < WIN_BYTES)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_ch == 3'(i)) begin
          case (rd_off)
            3'd0: begin rd_ok = 1'b1; rd_val = {31'b0, ch_rdy[i]}; end
            3'd1: begin rd_ok = 1'b1; rd_val = ch_a[32*i +: 32]; end
            3'd2: begin rd_ok = 1'b1; rd_val = ch_b[32*i +: 32]; end
            3'd3: begin rd_ok = 1'b1; rd_val = ch_p[64*i +: 32]; end
            3'd4: begin rd_ok = 1'b1; rd_val = ch_p[64*i+32 +: 32]; end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = (READ_LATENCY <= 1) ? R_DATA : R_WAIT;
      R_WAIT:  if (wait_cnt == 3'd0) r_next = R_DATA;
      R_DATA:  if (mem_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign enter_data = (r_state != R_DATA) && (r_next == R_DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= R_IDLE;
      ar_addr_q     <= '0;
      wait_cnt      <= 3'd0;
      mem_axi_rdata <= 32'h0;
      mem_axi_rresp <= 2'b00;
    end else begin
      r_state <= r_next;
      if (ar_fire) begin
        ar_addr_q <= mem_axi_araddr;
        wait_cnt  <= WAIT_INIT;
      end else if ((r_state == R_WAIT) && (wait_cnt != 3'd0)) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      if (enter_data) begin
        mem_axi_rdata <= rd_val;
        mem_axi_rresp <= rd_ok ? 2'b00 : 2'b10;
      end
    end
  end

endmodule
